// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack bus and
// feeds the IF/ID slot, with a one-entry skid buffer and redirect kill.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SKID = 2'd1,
    KILL = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] kill_addr_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;

  logic        slot_free;
  logic [31:0] pc_d;
  logic [31:0] redir_pc_d;

  assign slot_free  = !valid_q || !stall;
  assign pc_d       = pc_q + 32'd4;
  assign redir_pc_d = {redirect_pc[31:2], 2'b00};

  assign imem_req    = !reset && (state_q != SKID);
  assign imem_addr   = (state_q == KILL) ? kill_addr_q : pc_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      kill_addr_q  <= 32'h0;
      pc_out_q     <= 32'h0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
    end else if (redirect_valid) begin
      pc_q         <= redir_pc_d;
      pc_out_q     <= 32'h0;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= NOP_INSTR;
      case (state_q)
        RUN: begin
          // An in-flight request must be drained before refetching
          if (!imem_ack) begin
            kill_addr_q <= pc_q;
            state_q     <= KILL;
          end
        end
        SKID:    state_q <= RUN;
        KILL:    if (imem_ack) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end else begin
      case (state_q)
        RUN: begin
          if (imem_ack) begin
            pc_q <= pc_d;
            if (slot_free) begin
              pc_out_q <= pc_q;
              instr_q  <= imem_rdata;
              valid_q  <= 1'b1;
            end else begin
              skid_pc_q    <= pc_q;
              skid_instr_q <= imem_rdata;
              state_q      <= SKID;
            end
          end else if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
          end
        end
        SKID: begin
          if (!stall) begin
            pc_out_q <= skid_pc_q;
            instr_q  <= skid_instr_q;
            valid_q  <= 1'b1;
            state_q  <= RUN;
          end
        end
        KILL: begin
          if (imem_ack) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a latency-programmable
// instruction memory returning 0xC000_0000 | addr.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;

  logic        auto_ack;
  logic        man_ack;
  int          lat;
  int          cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid)
  );

  assign imem_ack   = auto_ack ? (imem_req && (cnt >= lat)) : man_ack;
  assign imem_rdata = 32'hC000_0000 | imem_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= 0;
    else if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input int l);
    reset    = 1'b1;
    auto_ack = 1'b1;
    man_ack  = 1'b0;
    lat      = l;
    stall    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // reset state
    start(0);
    reset = 1'b1;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr_out, NOP);
    check("rst_pc", pc_out, 32'h0);

    // T1 zero-wait stream
    start(0);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_req0", {31'h0, imem_req}, 32'h1);
    check("t1_v0", {31'h0, instr_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_valid", {31'h0, instr_valid}, 32'h1);
      check("t1_pc", pc_out, 32'(4 * i));
      check("t1_instr", instr_out, 32'hC000_0000 | 32'(4 * i));
      check("t1_addr", imem_addr, 32'(4 * (i + 1)));
    end

    // T2 three-cycle latency
    start(3);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr", imem_addr, 32'h0);
      check("t2_valid", {31'h0, instr_valid}, 32'h0);
      check("t2_instr", instr_out, NOP);
      tick();
    end
    tick();
    check("t2_pc", pc_out, 32'h0);
    check("t2_v", {31'h0, instr_valid}, 32'h1);
    check("t2_addr4", imem_addr, 32'h4);

    // T3 stall into skid
    start(0);
    tick();
    tick();
    check("t3_addr8", imem_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t3_req", {31'h0, imem_req}, 32'h0);
      check("t3_hold_pc", pc_out, 32'h4);
      check("t3_hold_in", instr_out, 32'hC000_0004);
      check("t3_hold_v", {31'h0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    check("t3_skid_pc", pc_out, 32'h8);
    check("t3_skid_in", instr_out, 32'hC000_0008);
    check("t3_req1", {31'h0, imem_req}, 32'h1);
    check("t3_addrC", imem_addr, 32'hC);
    tick();
    check("t3_pcC", pc_out, 32'hC);

    // T4 redirect while waiting
    start(0);
    tick();
    tick();
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    tick();
    check("t4_wait_a", imem_addr, 32'h8);
    check("t4_wait_v", {31'h0, instr_valid}, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("t4_kill_a", imem_addr, 32'h8);
    check("t4_kill_r", {31'h0, imem_req}, 32'h1);
    check("t4_kill_v", {31'h0, instr_valid}, 32'h0);
    tick();
    check("t4_kill_a2", imem_addr, 32'h8);
    man_ack = 1'b1;
    tick();
    man_ack  = 1'b0;
    auto_ack = 1'b1;
    check("t4_new_a", imem_addr, 32'h100);
    check("t4_disc_v", {31'h0, instr_valid}, 32'h0);
    tick();
    check("t4_pc", pc_out, 32'h100);
    check("t4_in", instr_out, 32'hC000_0100);
    check("t4_v", {31'h0, instr_valid}, 32'h1);

    // T5 redirect beats stall
    start(0);
    tick();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    check("t5_v", {31'h0, instr_valid}, 32'h0);
    check("t5_in", instr_out, NOP);
    check("t5_pc", pc_out, 32'h0);
    check("t5_addr", imem_addr, 32'h100);
    tick();
    check("t5_pc2", pc_out, 32'h100);

    // T6 reset mid-wait with ack during reset
    start(3);
    tick();
    tick();
    reset    = 1'b1;
    #1;
    check("t6_req", {31'h0, imem_req}, 32'h0);
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    tick();
    tick();
    check("t6_v", {31'h0, instr_valid}, 32'h0);
    check("t6_in", instr_out, NOP);
    check("t6_pc", pc_out, 32'h0);
    check("t6_req2", {31'h0, imem_req}, 32'h0);
    man_ack  = 1'b0;
    auto_ack = 1'b1;
    lat      = 0;
    reset    = 1'b0;
    #1;
    check("t6_addr", imem_addr, 32'h0);
    tick();
    check("t6_first", pc_out, 32'h0);
    check("t6_fv", {31'h0, instr_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
